// File: rtl/sbinit_pattern_fsm.sv
// Sideband-initialisation pattern engine. Drives the SBINIT clock/data
// pattern on the sideband TX mux inputs, detects the partner pattern on the
// retimed RX pins, sends the tail iterations and reports done or timeout.
// All outputs are registered; 1 UI equals one clk_800MHz cycle.
module sbinit_pattern_fsm #(
  parameter int unsigned PATTERN_UI     = 64,
  parameter int unsigned GAP_UI         = 32,
  parameter int unsigned DETECT_ITER    = 2,
  parameter int unsigned TAIL_ITER      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 8000
) (
  input  logic clk_800MHz,
  input  logic reset,
  input  logic enable_i,
  input  logic SB_clkPin_RX_i,
  input  logic SB_dataPin_RX_i,
  output logic SB_clkPin_TX_o,
  output logic SB_dataPin_TX_o,
  output logic pattern_detected_o,
  output logic done_o,
  output logic timeout_o
);

  localparam int unsigned ITER_UI = PATTERN_UI + GAP_UI;
  localparam int unsigned UI_W    = $clog2(ITER_UI);
  localparam int unsigned RUN_W   = $clog2(PATTERN_UI + 2);
  localparam int unsigned GOOD_W  = $clog2(DETECT_ITER + 1);
  localparam int unsigned ITER_W  = (TAIL_ITER > 1) ? $clog2(TAIL_ITER) : 1;
  localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES);

  localparam logic [UI_W-1:0]   UI_LAST   = UI_W'(ITER_UI - 1);
  localparam logic [UI_W-1:0]   UI_PAT    = UI_W'(PATTERN_UI);
  localparam logic [RUN_W-1:0]  RUN_FULL  = RUN_W'(PATTERN_UI);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(PATTERN_UI + 1);
  localparam logic [GOOD_W-1:0] GOOD_DET  = GOOD_W'(DETECT_ITER);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(TAIL_ITER - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StSend     = 3'd1;
  localparam logic [2:0] StSendTail = 3'd2;
  localparam logic [2:0] StDone     = 3'd3;
  localparam logic [2:0] StTimeout  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [UI_W-1:0]   ui_cnt_q, ui_cnt_d;
  logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [GOOD_W-1:0] good_iter_q, good_iter_d;
  logic              prev_data_q, prev_data_d;
  logic              clk_tx_q, clk_tx_d;
  logic              data_tx_q, data_tx_d;
  logic              detected_q, detected_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;

  // Next-state logic for the FSM, TX pattern counters and RX detector.
  always_comb begin
    logic            exp_bit;
    logic            det_hit;
    logic [UI_W-1:0] ui_next;

    state_d     = state_q;
    ui_cnt_d    = ui_cnt_q;
    iter_cnt_d  = iter_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    run_d       = run_q;
    good_iter_d = good_iter_q;
    prev_data_d = prev_data_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    exp_bit     = 1'b0;
    det_hit     = 1'b0;
    ui_next     = (ui_cnt_q == UI_LAST) ? '0 : ui_cnt_q + 1'b1;

    // The detector only listens while we are still searching.
    if (state_q == StSend) begin
      if (SB_clkPin_RX_i) begin
        exp_bit     = (run_q == '0) ? 1'b1 : ~prev_data_q;
        prev_data_d = SB_dataPin_RX_i;
        if (SB_dataPin_RX_i == exp_bit) begin
          run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + 1'b1;
        end else begin
          run_d       = '0;
          good_iter_d = '0;
        end
      end else if (run_q != '0) begin
        // End of a burst: only an exact-length burst counts as good.
        if (run_q == RUN_FULL) begin
          good_iter_d = (good_iter_q == GOOD_DET) ? GOOD_DET : good_iter_q + 1'b1;
        end else begin
          good_iter_d = '0;
        end
        run_d = '0;
      end
      det_hit = (good_iter_d == GOOD_DET);
    end
    detected_d = detected_q | det_hit;

    case (state_q)
      StIdle: begin
        state_d    = StSend;
        ui_cnt_d   = '0;
        iter_cnt_d = '0;
        tmo_cnt_d  = '0;
      end
      StSend: begin
        ui_cnt_d = ui_next;
        if (ui_cnt_q == UI_LAST && detected_q) begin
          state_d    = StSendTail;
          iter_cnt_d = '0;
        end else if (!detected_q && !det_hit) begin
          // A detection in the terminal cycle wins and freezes the budget.
          if (tmo_cnt_q == TMO_LAST) begin
            state_d   = StTimeout;
            timeout_d = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
        end
      end
      StSendTail: begin
        ui_cnt_d = ui_next;
        if (ui_cnt_q == UI_LAST) begin
          if (iter_cnt_q == ITER_LAST) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            iter_cnt_d = iter_cnt_q + 1'b1;
          end
        end
      end
      StDone, StTimeout: begin
      end
      default: state_d = StIdle;
    endcase

    // Dropping enable aborts from any state, including mid-burst.
    if (!enable_i) begin
      state_d     = StIdle;
      ui_cnt_d    = '0;
      iter_cnt_d  = '0;
      tmo_cnt_d   = '0;
      run_d       = '0;
      good_iter_d = '0;
      prev_data_d = 1'b0;
      detected_d  = 1'b0;
      done_d      = 1'b0;
      timeout_d   = 1'b0;
    end

    // Pins are registered from the UI being entered, so UI0 shows on entry.
    if (state_d == StSend || state_d == StSendTail) begin
      clk_tx_d  = (ui_cnt_d < UI_PAT);
      data_tx_d = clk_tx_d & ~ui_cnt_d[0];
    end else begin
      clk_tx_d  = 1'b0;
      data_tx_d = 1'b0;
    end
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk_800MHz or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      ui_cnt_q    <= '0;
      iter_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      run_q       <= '0;
      good_iter_q <= '0;
      prev_data_q <= 1'b0;
      clk_tx_q    <= 1'b0;
      data_tx_q   <= 1'b0;
      detected_q  <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ui_cnt_q    <= ui_cnt_d;
      iter_cnt_q  <= iter_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      run_q       <= run_d;
      good_iter_q <= good_iter_d;
      prev_data_q <= prev_data_d;
      clk_tx_q    <= clk_tx_d;
      data_tx_q   <= data_tx_d;
      detected_q  <= detected_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign SB_clkPin_TX_o     = clk_tx_q;
  assign SB_dataPin_TX_o    = data_tx_q;
  assign pattern_detected_o = detected_q;
  assign done_o             = done_q;
  assign timeout_o          = timeout_q;

endmodule

// File: tb/tb_sbinit_pattern_fsm.sv
// Directed bench for sbinit_pattern_fsm. Expected output vectors are queued
// against a cycle number when a run is set up and compared when that cycle
// is reached. Output vector order: {clk_tx, data_tx, detected, done, timeout}.
module tb_sbinit_pattern_fsm;

  localparam int MODE_LOOP = 0;  // RX = TX through one register
  localparam int MODE_ZERO = 1;  // RX tied low
  localparam int MODE_PART = 2;  // scripted partner pattern

  localparam logic [4:0] ALL = 5'b11111;
  localparam logic [4:0] DET = 5'b00100;

  logic clk_800MHz = 1'b0;
  logic reset = 1'b1;
  logic enable_i = 1'b0;
  logic rx_clk = 1'b0;
  logic rx_data = 1'b0;
  logic tx_clk, tx_data, detected, done, timeout;

  sbinit_pattern_fsm dut (
    .clk_800MHz         (clk_800MHz),
    .reset              (reset),
    .enable_i           (enable_i),
    .SB_clkPin_RX_i     (rx_clk),
    .SB_dataPin_RX_i    (rx_data),
    .SB_clkPin_TX_o     (tx_clk),
    .SB_dataPin_TX_o    (tx_data),
    .pattern_detected_o (detected),
    .done_o             (done),
    .timeout_o          (timeout)
  );

  always #5 clk_800MHz = ~clk_800MHz;

  typedef struct {
    string      tag;
    int         cyc;
    logic [4:0] exp;
    logic [4:0] mask;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   mode = MODE_ZERO;
  logic tp_clk = 1'b0;
  logic tp_data = 1'b0;
  int   short_iter = -1;
  int   flip_iter = -1;
  int   flip_pos = 0;

  function automatic logic [4:0] obs_vec();
    return {tx_clk, tx_data, detected, done, timeout};
  endfunction

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp,
                       input logic [4:0] mask);
    checks++;
    assert ((obs & mask) === (exp & mask)) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b mask=%b", tag, cyc, obs, exp, mask);
    end
  endtask

  task automatic expect_at(input string tag, input int c, input logic [4:0] exp,
                           input logic [4:0] mask);
    exp_t e;
    e.tag  = tag;
    e.cyc  = c;
    e.exp  = exp;
    e.mask = mask;
    sb.push_back(e);
  endtask

  // Partner pattern at partner UI u: 96-UI iterations, optional short burst
  // and optional single flipped data bit.
  function automatic logic [1:0] partner(input int u);
    int   it, pos, blen;
    logic c, d;
    if (u < 0) return 2'b00;
    it   = u / 96;
    pos  = u % 96;
    blen = (it == short_iter) ? 63 : 64;
    c    = (pos < blen);
    d    = c && (pos % 2 == 0);
    if (it == flip_iter && pos == flip_pos) d = ~d;
    return {c, d};
  endfunction

  // One clock: sample after the edge, score due entries, then drive RX.
  task automatic step();
    exp_t       e;
    logic [1:0] p;
    @(posedge clk_800MHz);
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      check(e.tag, obs_vec(), e.exp, e.mask);
    end
    case (mode)
      MODE_LOOP: begin
        rx_clk  = tp_clk;
        rx_data = tp_data;
        tp_clk  = tx_clk;
        tp_data = tx_data;
      end
      MODE_PART: begin
        p       = partner(cyc - 1);
        rx_clk  = p[1];
        rx_data = p[0];
      end
      default: begin
        rx_clk  = 1'b0;
        rx_data = 1'b0;
      end
    endcase
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  // The next edge becomes cycle 0 of a fresh run.
  task automatic start_run(input int m);
    mode     = m;
    rx_clk   = 1'b0;
    rx_data  = 1'b0;
    tp_clk   = 1'b0;
    tp_data  = 1'b0;
    cyc      = -1;
    enable_i = 1'b1;
  endtask

  task automatic stop_run(input string tag);
    enable_i = 1'b0;
    expect_at(tag, cyc + 1, 5'b00000, ALL);
    step();
  endtask

  initial begin
    // Reset state, both asynchronously and across a clock edge.
    #2;
    check("reset_async", obs_vec(), 5'b00000, ALL);
    @(posedge clk_800MHz);
    #1;
    check("reset_hold", obs_vec(), 5'b00000, ALL);
    #2 reset = 1'b0;
    cyc = 0;
    expect_at("idle_disabled", 2, 5'b00000, ALL);
    run_to(2);

    // Loopback with default parameters.
    start_run(MODE_LOOP);
    expect_at("lb_ui0", 0, 5'b11000, ALL);
    expect_at("lb_ui1", 1, 5'b10000, ALL);
    expect_at("lb_ui63", 63, 5'b10000, ALL);
    expect_at("lb_gap64", 64, 5'b00000, ALL);
    expect_at("lb_gap95", 95, 5'b00000, ALL);
    expect_at("lb_iter1_ui0", 96, 5'b11000, ALL);
    expect_at("lb_pre_det", 161, 5'b00000, ALL);
    expect_at("lb_det", 162, 5'b00100, ALL);
    expect_at("lb_tail_ui0", 192, 5'b11100, ALL);
    expect_at("lb_tail_ui1", 193, 5'b10100, ALL);
    expect_at("lb_pre_done", 575, 5'b00100, ALL);
    expect_at("lb_done", 576, 5'b00110, ALL);
    expect_at("lb_done_hold", 620, 5'b00110, ALL);
    run_to(620);
    stop_run("lb_disable");

    // RX tied low: timeout after the SEND budget.
    start_run(MODE_ZERO);
    expect_at("tmo_pre", 7999, 5'b10000, ALL);
    expect_at("tmo_hit", 8000, 5'b00001, ALL);
    expect_at("tmo_hold", 8050, 5'b00001, ALL);
    run_to(8050);
    stop_run("tmo_disable");

    // 63-UI partner burst first: it must not count towards detection.
    short_iter = 0;
    flip_iter  = -1;
    start_run(MODE_PART);
    expect_at("short_no_det", 162, 5'b00000, ALL);
    expect_at("short_pre_det", 257, 5'b00000, ALL);
    expect_at("short_det", 258, 5'b00100, ALL);
    expect_at("short_tail_ui0", 288, 5'b11100, ALL);
    expect_at("short_pre_done", 671, 5'b00100, ALL);
    expect_at("short_done", 672, 5'b00110, ALL);
    run_to(672);
    stop_run("short_disable");

    // Flipped bit in the second partner burst clears the good count.
    short_iter = -1;
    flip_iter  = 1;
    flip_pos   = 30;
    start_run(MODE_PART);
    expect_at("flip_no_det_it1", 162, 5'b00000, ALL);
    expect_at("flip_no_det_it2", 258, 5'b00000, ALL);
    expect_at("flip_pre_det", 353, 5'b00000, ALL);
    expect_at("flip_det", 354, 5'b00100, ALL);
    expect_at("flip_tail_ui0", 384, 5'b11100, ALL);
    expect_at("flip_done", 768, 5'b00110, ALL);
    run_to(768);
    stop_run("flip_disable");
    flip_iter = -1;

    // Enable dropped mid-burst, then restarted from UI0.
    start_run(MODE_LOOP);
    expect_at("abort_ui0", 0, 5'b11000, ALL);
    expect_at("abort_ui40", 40, 5'b11000, ALL);
    run_to(40);
    enable_i = 1'b0;
    expect_at("abort_idle", 41, 5'b00000, ALL);
    expect_at("abort_idle_hold", 42, 5'b00000, ALL);
    run_to(42);
    start_run(MODE_LOOP);
    expect_at("restart_ui0", 0, 5'b11000, ALL);
    expect_at("restart_ui1", 1, 5'b10000, ALL);
    expect_at("restart_ui2", 2, 5'b11000, ALL);
    expect_at("restart_pre_det", 161, 5'b00000, DET);
    expect_at("restart_det", 162, 5'b00100, ALL);
    run_to(162);
    stop_run("restart_disable");

    // Asynchronous reset pulse between edges during SEND_TAIL.
    start_run(MODE_LOOP);
    expect_at("rst_tail_ui8", 200, 5'b11100, ALL);
    run_to(200);
    #3 reset = 1'b1;
    #1;
    check("rst_async_clear", obs_vec(), 5'b00000, ALL);
    @(posedge clk_800MHz);
    #1;
    check("rst_held", obs_vec(), 5'b00000, ALL);
    #3 reset = 1'b0;
    start_run(MODE_LOOP);
    expect_at("rst_release_ui0", 0, 5'b11000, ALL);
    expect_at("rst_release_ui1", 1, 5'b10000, ALL);
    run_to(1);
    stop_run("rst_disable");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sbinit_pattern_fsm.md
# sbinit_pattern_fsm

Sideband-initialisation pattern engine for the link-training state machine. While the LTSM holds the sideband TX pins in the SBINIT mux position, this block generates the SBINIT clock/data pattern on those mux inputs. It also detects the partner's pattern on the sideband RX pins, sends the required tail iterations, and reports done or timeout back to the LTSM. It runs entirely in the 800 MHz sideband domain; 1 UI = 1 clk_800MHz cycle.

## Interface
Parameters:
- PATTERN_UI, 64: UIs of the alternating burst per iteration.
- GAP_UI, 32: UIs of idle low following each burst.
- DETECT_ITER, 2: consecutive good RX iterations required for detection.
- TAIL_ITER, 4: full iterations sent after detection before done.
- TIMEOUT_CYCLES, 8000: SEND-state cycle budget before timeout.

Ports:
- clk_800MHz  input  1  sole clock.
- reset  input  1  asynchronous, active-high.
- enable_i  input  1  level from LTSM; high = run SBINIT; low = return to IDLE from any state.
- SB_clkPin_RX_i  input  1  partner sideband clock-valid, already retimed to clk_800MHz.
- SB_dataPin_RX_i  input  1  partner sideband data, already retimed to clk_800MHz.
- SB_clkPin_TX_o  output  1  feeds the LTSM SBINIT mux input for the clock pin; 1 = forwarded-clock burst active.
- SB_dataPin_TX_o  output  1  feeds the LTSM SBINIT mux input for the data pin.
- pattern_detected_o  output  1  sticky detection flag.
- done_o  output  1  SBINIT pattern phase complete; level.
- timeout_o  output  1  no detection within budget; level.

## Operation
- States: IDLE, SEND, SEND_TAIL, DONE, TIMEOUT. All outputs and counters are registered.
- Reset: state IDLE. All outputs are 0. Counters and the detector are cleared.
- IDLE, with enable_i=1: go to SEND with ui_cnt=0, iter_cnt=0, tmo_cnt=0.
- TX pattern in SEND and SEND_TAIL. ui_cnt runs 0..PATTERN_UI+GAP_UI-1 and wraps; each wrap is an iteration boundary.
  - ui_cnt<PATTERN_UI: clk_o=1, data_o = ~ui_cnt[0] (UI0 = 1, then 1,0,1,0…).
  - Otherwise: clk_o=0, data_o=0.
- RX detector, active in SEND only; it uses run (0..PATTERN_UI+1), good_iter, and prev_data.
  - Cycle with clk_rx=1: the expected value is 1 if run==0, else ~prev_data.
    - Match: run+1, saturating at PATTERN_UI+1.
    - Mismatch: run=0, good_iter=0.
  - Cycle with clk_rx=0 and run≠0: if run==PATTERN_UI, good_iter+1; else good_iter=0. Then run=0.
  - Gap length is not checked.
  - good_iter reaching DETECT_ITER sets pattern_detected_o. It stays set until IDLE.
- SEND → SEND_TAIL at the first iteration boundary where pattern_detected_o=1. iter_cnt is cleared there.
- SEND_TAIL: sends TAIL_ITER complete iterations. At the boundary ending the last one, go to DONE.
- DONE: pins 0, done_o=1. Hold until enable_i=0.
- SEND timeout: tmo_cnt increments each SEND cycle. When it reaches TIMEOUT_CYCLES-1 with no detection, go to TIMEOUT.
  - TIMEOUT: timeout_o=1, pins 0. Hold until enable_i=0.
  - Detection and the timeout terminal count in the same cycle: detection wins, and tmo_cnt freezes.
- enable_i=0 in any state: next edge goes to IDLE. All outputs and the detector are cleared, including mid-burst.
- reset mid-operation: immediate (asynchronous) return to the reset values.

## Timing
- Cycle 0 is the edge that samples enable_i=1 in IDLE. At that same edge, state becomes SEND and the outputs show UI0 (clk_o=1, data_o=1).
- Iteration length is PATTERN_UI+GAP_UI = 96 cycles. Burst occupies cycles 0..63; gap occupies 64..95.
- pattern_detected_o rises on the edge after the RX sample that increments good_iter to DETECT_ITER.
- done_o and timeout_o rise on the edge that enters DONE or TIMEOUT. The pins drop to 0 on that same edge.
- No combinational path from any input to any output.

## Test plan
- Loopback through one register (TX → RX, 1-cycle delay), defaults:
  - pattern_detected_o=1 at cycle 162.
  - SEND_TAIL entered at cycle 192.
  - done_o=1 at cycle 576.
  - Pins 0 from cycle 576.
- RX tied to 0: timeout_o=1 at cycle 8000, pattern_detected_o=0, pins 0.
- Partner burst of 63 UIs, then good bursts: good_iter resets; detection only after two consecutive 64-UI bursts.
- Single flipped data bit mid-burst in the 2nd RX iteration: no detection at that iteration end; detection one iteration later.
- enable_i dropped at cycle 40 (mid-burst): at cycle 41, state IDLE and all outputs 0. Re-enable restarts at UI0.
- Asynchronous reset pulse between clock edges during SEND_TAIL: all outputs 0 immediately; IDLE after release.
